jtframe_sdram_ctrl: RTL and testbench
=====================================

// Module: jtframe_sdram_ctrl
// PURPOSE
//  Single-port SDRAM controller for an MT48LC16M16A2-class 16-bit SDRAM. Game-level simulation top, 96 MHz clock, CAS latency 2.
//  - Runs the power-up init sequence.
//  - Then serves one 8-cycle slot per cen12 pulse: a video/CPU word read, an auto-refresh, or a ROM-download byte write.
//  - loop_rst holds the game logic in reset until the SDRAM is ready.
// PARAMETERS
//  INIT_WAIT  9600  clk cycles of NOP after reset before PRECHARGE ALL (100 us at 96 MHz)
//  MODE_REG   13'h020  mode register value: burst 1, sequential, CL=2
// PORTS
//  clk          in   1   system clock, 96 MHz; all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  cen12        in   1   clock enable, one cycle in 8; a high cycle starts a slot
//  H0           in   1   half-line phase; refresh only in slots starting with H0=1
//  autorefresh  in   1   refresh request, sampled at slot start
//  sdram_addr   in   22  read word address: row=[21:9], col=[8:0], bank 0
//  data_read    out  16  last word read, registered
//  loop_rst     out  1   high until init completes
//  downloading  in   1   ROM download active; read slots are disabled
//  prog_addr    in   25  download byte address: word=[22:1], byte lane=[0]
//  prog_data    in   8   download byte
//  prog_we      in   1   one-cycle write strobe
//  SDRAM_DQ     io   16  data bus; driven only in the WRITE cycle
//  SDRAM_A      out  13  address
//  SDRAM_BA     out  2   bank, always 0
//  SDRAM_DQML/DQMH out 1 byte masks
//  SDRAM_nCS/nRAS/nCAS/nWE out 1 command
//  SDRAM_CKE    out  1   clock enable
// BEHAVIOUR
//  Reset values:
//  - command NOP: nCS=0, nRAS=nCAS=nWE=1; CKE=1.
//  - A=0, BA=0, DQM=2'b11, DQ=Z, data_read=0, loop_rst=1, write-pending=0.
//  Init FSM: WAIT(INIT_WAIT) -> PRECHARGE ALL (A10=1) -> 2 NOP -> AUTO REFRESH -> 7 NOP -> AUTO REFRESH -> 7 NOP -> LOAD MODE (A=MODE_REG) -> 2 NOP -> IDLE.
//  - loop_rst falls on entry to IDLE and stays low until rst.
//  - rst during any state restarts init from WAIT.
//  Slot arbitration in IDLE on a cen12 cycle (slot counter s=0..7, then back to IDLE):
//  - priority 1: write pending -> WRITE slot
//  - priority 2: autorefresh & H0 & !downloading -> REFRESH slot
//  - priority 3: !downloading -> READ slot
//  - otherwise the slot stays NOP
//  - cen12 seen while a slot is busy is ignored; the designed cadence never overlaps.
//  READ slot:
//  - s0 ACTIVE, row=sdram_addr[21:9], address latched here.
//  - s2 READ, A10=1 (auto-precharge), A[8:0]=col, DQM=00.
//  - s4 DQ sampled (CL2); s5 data_read updated.
//  - all other cycles NOP.
//  WRITE slot:
//  - s0 ACTIVE, row=prog_addr[22:10].
//  - s2 WRITE with auto-precharge, col=prog_addr[9:1], DQ={prog_data,prog_data}.
//  - DQML=prog_addr[0], DQMH=~prog_addr[0]: even address writes the low byte.
//  - pending clears at s2; DQ=Z from s3.
//  REFRESH slot: s0 AUTO REFRESH, s1..s7 NOP.
//  prog_we sets pending and latches addr/data.
//  - A strobe while pending overwrites the latch; the host spaces strobes at least 8 cycles apart.
//  - Simultaneous prog_we and WRITE s2: the new byte stays pending.
//  data_read holds its value in non-read slots.
// CONFIGURATION
//  JTFRAME_SDRAM_DLREFRESH_EN
//  - defined: refresh also allowed while downloading=1, whenever no write is pending.
//  - undefined: no refresh during download.
// TESTING
//  1. rst high 4 cycles then low.
//     - loop_rst=1 for INIT_WAIT+~24 cycles.
//     - PRECHARGE with A10=1 seen.
//     - exactly 2 REFRESH commands seen.
//     - LOAD MODE with A=13'h020 seen; then loop_rst=0.
//  2. Model holds 0xBEEF at word 0x12345; sdram_addr=22'h012345, one cen12 pulse.
//     - ACTIVE row 0x091, then READ col 0x145 two cycles later.
//     - data_read=16'hBEEF 5 cycles after slot start.
//  3. downloading=1; prog_we at 0x000000 data 0x34, then 0x000001 data 0x12; then read word 0.
//     - data_read=16'h1234.
//  4. autorefresh=1, H0=1 at cen12: REFRESH command, no READ in that slot, data_read unchanged.
//  5. autorefresh=1, H0=0: READ performed.
//  6. rst asserted mid-READ slot: NOP next cycle, loop_rst=1, DQ=Z, init restarts.

Source files
------------

// File: rtl/jtframe_sdram_ctrl.sv
// Single-port SDRAM controller: power-up init, then one 8-cycle read/refresh/write slot per cen12.
// Optional macro JTFRAME_SDRAM_DLREFRESH_EN allows auto-refresh while a ROM download is active.
module jtframe_sdram_ctrl #(
  parameter int          INIT_WAIT = 9600,
  parameter logic [12:0] MODE_REG  = 13'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen12,
  input  logic        H0,
  input  logic        autorefresh,
  input  logic [21:0] sdram_addr,
  output logic [15:0] data_read,
  output logic        loop_rst,
  input  logic        downloading,
  input  logic [24:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic        prog_we,
  inout  wire  [15:0] SDRAM_DQ,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic        SDRAM_DQML,
  output logic        SDRAM_DQMH,
  output logic        SDRAM_nCS,
  output logic        SDRAM_nRAS,
  output logic        SDRAM_nCAS,
  output logic        SDRAM_nWE,
  output logic        SDRAM_CKE
);

  localparam int CW = ($clog2(INIT_WAIT) > 5) ? $clog2(INIT_WAIT) : 5;

  // {nCS, nRAS, nCAS, nWE}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_IDLE, ST_SLOT} state_t;
  typedef enum logic [1:0] {SL_READ, SL_WRITE, SL_REF} slot_t;

  state_t      state_q, state_d;
  slot_t       kind_q, kind_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  s_q, s_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] a_q, a_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [15:0] data_read_q, data_read_d;
  logic        loop_rst_q, loop_rst_d;
  logic [8:0]  col_q, col_d;
  logic [22:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        pend_q, pend_d;
  logic        wr_issue;
  logic        slot_free;
  logic        refresh_ok;
  logic        prog_we_ok;

  // Init step k (after PRECHARGE ALL at step 0) -> command issued at that step
  function automatic logic [3:0] init_cmd(input logic [CW-1:0] step);
    case (step)
      CW'(3), CW'(11): init_cmd = CMD_REF;
      CW'(19):         init_cmd = CMD_LMR;
      default:         init_cmd = CMD_NOP;
    endcase
  endfunction

`ifdef JTFRAME_SDRAM_DLREFRESH_EN
  assign refresh_ok = autorefresh & H0;
`else
  assign refresh_ok = autorefresh & H0 & ~downloading;
`endif

  // Only bank 0 is mapped, so strobes aimed above it are dropped
  assign prog_we_ok = prog_we & ~(|prog_addr[24:23]);

  // Next-state logic for init sequencing, slot arbitration and the download latch
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    cmd_d       = CMD_NOP;
    a_d         = a_q;
    dqm_d       = 2'b11;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    data_read_d = data_read_q;
    loop_rst_d  = loop_rst_q;
    col_d       = col_q;
    wr_issue    = 1'b0;
    slot_free   = (state_q == ST_IDLE) || ((state_q == ST_SLOT) && (s_q == 3'd7));
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          cmd_d   = CMD_PRE;
          a_d     = 13'h0400;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_INIT: begin
        if (cnt_q == CW'(21)) begin
          state_d    = ST_IDLE;
          loop_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          cmd_d = init_cmd(cnt_q + CW'(1));
          a_d   = MODE_REG;
        end
      end
      ST_IDLE, ST_SLOT: begin
        if (state_q == ST_SLOT) begin
          s_d = s_q + 3'd1;
          case (kind_q)
            SL_READ: begin
              if (s_q == 3'd1) begin
                cmd_d = CMD_READ;
                a_d   = {4'b0010, col_q};
                dqm_d = 2'b00;
              end else if (s_q == 3'd4) begin
                data_read_d = SDRAM_DQ;  // CL2: data valid two edges after READ
              end else begin
                data_read_d = data_read_q;
              end
            end
            SL_WRITE: begin
              if (s_q == 3'd1) begin
                cmd_d    = CMD_WR;
                a_d      = {4'b0010, wr_addr_q[9:1]};
                dqm_d    = {~wr_addr_q[0], wr_addr_q[0]};
                dq_oe_d  = 1'b1;
                dq_out_d = {wr_data_q, wr_data_q};
                wr_issue = 1'b1;
              end else begin
                dq_oe_d = 1'b0;
              end
            end
            SL_REF:  cmd_d = CMD_NOP;
            default: cmd_d = CMD_NOP;
          endcase
        end else begin
          s_d = s_q;
        end
        if (slot_free && cen12) begin
          s_d     = 3'd0;
          state_d = ST_SLOT;
          if (pend_q) begin
            kind_d = SL_WRITE;
            cmd_d  = CMD_ACT;
            a_d    = wr_addr_q[22:10];
          end else if (refresh_ok) begin
            kind_d = SL_REF;
            cmd_d  = CMD_REF;
          end else if (!downloading) begin
            kind_d = SL_READ;
            cmd_d  = CMD_ACT;
            a_d    = sdram_addr[21:9];
            col_d  = sdram_addr[8:0];
          end else begin
            state_d = ST_IDLE;
          end
        end else if (slot_free) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_WAIT;
    endcase
    // A strobe coinciding with the WRITE command keeps the new byte pending
    pend_d = (pend_q & ~wr_issue) | prog_we_ok;
    if (prog_we_ok) begin
      wr_addr_d = prog_addr[22:0];
      wr_data_d = prog_data;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // State and registered SDRAM outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      kind_q      <= SL_READ;
      cnt_q       <= '0;
      s_q         <= 3'd0;
      cmd_q       <= CMD_NOP;
      a_q         <= 13'h0000;
      dqm_q       <= 2'b11;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= 16'h0000;
      data_read_q <= 16'h0000;
      loop_rst_q  <= 1'b1;
      col_q       <= 9'h000;
      wr_addr_q   <= 23'h000000;
      wr_data_q   <= 8'h00;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      data_read_q <= data_read_d;
      loop_rst_q  <= loop_rst_d;
      col_q       <= col_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pend_q      <= pend_d;
    end
  end

  assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd_q;
  assign SDRAM_A    = a_q;
  assign SDRAM_BA   = 2'b00;
  assign SDRAM_CKE  = 1'b1;
  assign SDRAM_DQMH = dqm_q[1];
  assign SDRAM_DQML = dqm_q[0];
  assign SDRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign data_read  = data_read_q;
  assign loop_rst   = loop_rst_q;

endmodule

// File: tb/tb_jtframe_sdram_ctrl.sv
// Bench for jtframe_sdram_ctrl: behavioural CL2 SDRAM model, read-data scoreboard,
// table of read/refresh slots and hand sequences for init, download and mid-slot reset.
module tb_jtframe_sdram_ctrl;
  localparam int INIT_WAIT = 9600;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, cen12 = 1'b0, h0 = 1'b0, autorefresh = 1'b0, downloading = 1'b0;
  logic [21:0] sdram_addr = 22'h0;
  logic [24:0] prog_addr = 25'h0;
  logic [7:0]  prog_data = 8'h0;
  logic        prog_we = 1'b0;
  logic [15:0] data_read;
  logic        loop_rst;
  wire  [15:0] sdram_dq;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic        dqml, dqmh, ncs, nras, ncas, nwe, cke;

  jtframe_sdram_ctrl dut (
    .clk(clk), .rst(rst), .cen12(cen12), .H0(h0), .autorefresh(autorefresh),
    .sdram_addr(sdram_addr), .data_read(data_read), .loop_rst(loop_rst),
    .downloading(downloading), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .SDRAM_DQ(sdram_dq), .SDRAM_A(sdram_a), .SDRAM_BA(sdram_ba), .SDRAM_DQML(dqml),
    .SDRAM_DQMH(dqmh), .SDRAM_nCS(ncs), .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas),
    .SDRAM_nWE(nwe), .SDRAM_CKE(cke)
  );

  logic [3:0] cmd;
  assign cmd = {ncs, nras, ncas, nwe};

  // SDRAM model: bank 0, 17-bit word space, CAS latency 2
  logic [15:0] mem [0:131071];
  logic [7:0]  m_row;
  logic        rd_v1, m_oe;
  logic [15:0] rd_d1, m_dout;
  logic        pre_en = 1'b0;
  logic [16:0] pre_addr = 17'h0;
  logic [15:0] pre_data = 16'h0;
  logic [16:0] m_waddr;
  assign m_waddr  = {m_row, sdram_a[8:0]};
  assign sdram_dq = m_oe ? m_dout : 16'hzzzz;

  always @(posedge clk) begin
    m_oe   <= rd_v1 & ~rst;
    m_dout <= rd_d1;
    rd_v1  <= 1'b0;
    if (pre_en) mem[pre_addr] <= pre_data;
    else begin
      case (cmd)
        C_ACT:  m_row <= sdram_a[7:0];
        C_READ: begin rd_v1 <= 1'b1; rd_d1 <= mem[m_waddr]; end
        C_WR:   mem[m_waddr] <= {dqmh ? mem[m_waddr][15:8] : sdram_dq[15:8],
                                 dqml ? mem[m_waddr][7:0]  : sdram_dq[7:0]};
        default: ;
      endcase
    end
  end

  int total = 0, bad = 0;
  int n_pre = 0, n_ref = 0, n_lmr = 0, rd_cd = 0;
  logic [12:0] lmr_a = 13'h0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Command monitor and read-data scoreboard (data_read valid 3 cycles after READ)
  initial begin
    forever begin
      @(negedge clk);
      if (cmd == C_PRE && sdram_a[10]) n_pre++;
      if (cmd == C_REF) n_ref++;
      if (cmd == C_LMR) begin n_lmr++; lmr_a = sdram_a; end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_read: data_read=%0h, no read expected", data_read);
          end else check("read_data", data_read, exp_q.pop_front());
        end
      end
      if (cmd == C_READ) rd_cd = 3;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0]  cap_cmd [8];
  logic [12:0] cap_a [8];
  logic [1:0]  cap_dqm [8];
  logic [15:0] cap_dq [8];
  logic        cap_oe [8];

  task automatic do_slot(input logic we1, input logic [24:0] wa, input logic [7:0] wd);
    @(posedge clk); #1 cen12 = 1'b1;
    @(posedge clk); #1 cen12 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap_cmd[i] = cmd; cap_a[i] = sdram_a; cap_dqm[i] = {dqmh, dqml};
      cap_dq[i] = sdram_dq; cap_oe[i] = dut.dq_oe_q;
      if (we1 && i == 1) begin prog_addr = wa; prog_data = wd; prog_we = 1'b1; end
      if (i == 2) prog_we = 1'b0;
    end
  endtask

  task automatic strobe(input logic [24:0] wa, input logic [7:0] wd);
    @(posedge clk); #1 prog_addr = wa; prog_data = wd; prog_we = 1'b1;
    @(posedge clk); #1 prog_we = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int lr_cnt;
    lr_cnt = 0;
    while (loop_rst && lr_cnt < 20000) begin
      @(negedge clk);
      if (loop_rst) lr_cnt++;
    end
    check({name, "_done"}, loop_rst, 1'b0);
    check({name, "_len_ok"}, (lr_cnt >= INIT_WAIT + 20) && (lr_cnt <= INIT_WAIT + 30), 1'b1);
  endtask

  typedef struct {
    logic [21:0] addr;
    logic h0, aref, dl;
    logic [3:0] exp_c0;
    logic [15:0] exp_dr;
  } vec_t;
  vec_t vecs [7];
  logic [3:0] dl_ref_cmd;
  int ref0, lmr0;

  initial begin
`ifdef JTFRAME_SDRAM_DLREFRESH_EN
    dl_ref_cmd = C_REF;
`else
    dl_ref_cmd = C_NOP;
`endif
    vecs[0] = '{22'h012345, 1'b0, 1'b0, 1'b0, C_ACT, 16'hBEEF};
    vecs[1] = '{22'h012345, 1'b1, 1'b1, 1'b0, C_REF, 16'hBEEF};
    vecs[2] = '{22'h01FFFF, 1'b0, 1'b1, 1'b0, C_ACT, 16'hA5C3};
    vecs[3] = '{22'h012345, 1'b1, 1'b0, 1'b0, C_ACT, 16'hBEEF};
    vecs[4] = '{22'h01FFFF, 1'b0, 1'b0, 1'b1, C_NOP, 16'hBEEF};
    vecs[5] = '{22'h01FFFF, 1'b1, 1'b1, 1'b1, dl_ref_cmd, 16'hBEEF};
    vecs[6] = '{22'h01FFFF, 1'b1, 1'b0, 1'b0, C_ACT, 16'hA5C3};

    // Reset with model preload
    @(posedge clk); #1 pre_en = 1'b1; pre_addr = 17'h12345; pre_data = 16'hBEEF;
    @(posedge clk); #1 pre_addr = 17'h1FFFF; pre_data = 16'hA5C3;
    @(posedge clk); #1 pre_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd", cmd, C_NOP);
    check("rst_cke", cke, 1'b1);
    check("rst_a", sdram_a, 13'h0000);
    check("rst_ba", sdram_ba, 2'b00);
    check("rst_dqm", {dqmh, dqml}, 2'b11);
    check("rst_dq_released", dut.dq_oe_q, 1'b0);
    check("rst_data_read", data_read, 16'h0000);
    check("rst_loop_rst", loop_rst, 1'b1);
    @(posedge clk); #1 rst = 1'b0;

    wait_init("init");
    check("init_precharge", n_pre, 1);
    check("init_refresh", n_ref, 2);
    check("init_lmr", n_lmr, 1);
    check("init_mode", lmr_a, 13'h020);

    // Table of read / refresh / idle slots
    for (int i = 0; i < 7; i++) begin
      sdram_addr = vecs[i].addr; h0 = vecs[i].h0;
      autorefresh = vecs[i].aref; downloading = vecs[i].dl;
      if (vecs[i].exp_c0 == C_ACT) exp_q.push_back(vecs[i].exp_dr);
      do_slot(1'b0, 25'h0, 8'h0);
      check($sformatf("v%0d_s0_cmd", i), cap_cmd[0], vecs[i].exp_c0);
      if (vecs[i].exp_c0 == C_ACT) begin
        check($sformatf("v%0d_row", i), cap_a[0], {4'b0000, vecs[i].addr[21:9]});
        check($sformatf("v%0d_s2_cmd", i), cap_cmd[2], C_READ);
        check($sformatf("v%0d_col", i), cap_a[2], {4'b0010, vecs[i].addr[8:0]});
        check($sformatf("v%0d_dqm", i), cap_dqm[2], 2'b00);
      end else begin
        check($sformatf("v%0d_no_read", i), cap_cmd[2], C_NOP);
      end
      if (i == 0) begin
        check("rd_row_091", cap_a[0], 13'h0091);
        check("rd_col_145", cap_a[2], 13'h0545);
      end
      check($sformatf("v%0d_data_read", i), data_read, vecs[i].exp_dr);
    end
    h0 = 1'b0; autorefresh = 1'b0;

    // ROM download: two byte writes into word 0
    downloading = 1'b1;
    strobe(25'h0000000, 8'h34);
    do_slot(1'b0, 25'h0, 8'h0);
    check("wr0_s0_cmd", cap_cmd[0], C_ACT);
    check("wr0_s2_cmd", cap_cmd[2], C_WR);
    check("wr0_a", cap_a[2], 13'h0400);
    check("wr0_dqm", cap_dqm[2], 2'b10);
    check("wr0_dq", cap_dq[2], 16'h3434);
    check("wr0_oe_s2", cap_oe[2], 1'b1);
    check("wr0_oe_s3", cap_oe[3], 1'b0);
    strobe(25'h0000001, 8'h12);
    do_slot(1'b0, 25'h0, 8'h0);
    check("wr1_s2_cmd", cap_cmd[2], C_WR);
    check("wr1_dqm", cap_dqm[2], 2'b01);
    check("wr1_dq", cap_dq[2], 16'h1212);
    do_slot(1'b0, 25'h0, 8'h0);
    check("wr_pending_cleared", cap_cmd[0], C_NOP);

    // Strobe landing on the WRITE edge stays pending
    strobe(25'h0000002, 8'h56);
    do_slot(1'b1, 25'h0000003, 8'h78);
    check("wr2_s2_cmd", cap_cmd[2], C_WR);
    check("wr2_a", cap_a[2], 13'h0401);
    check("wr2_dq", cap_dq[2], 16'h5656);
    do_slot(1'b0, 25'h0, 8'h0);
    check("wr3_still_pending", cap_cmd[2], C_WR);
    check("wr3_dqm", cap_dqm[2], 2'b01);
    check("wr3_dq", cap_dq[2], 16'h7878);
    do_slot(1'b0, 25'h0, 8'h0);
    check("wr3_cleared", cap_cmd[0], C_NOP);

    downloading = 1'b0;
    sdram_addr = 22'h000000; exp_q.push_back(16'h1234);
    do_slot(1'b0, 25'h0, 8'h0);
    check("dl_word0", data_read, 16'h1234);
    sdram_addr = 22'h000001; exp_q.push_back(16'h7856);
    do_slot(1'b0, 25'h0, 8'h0);
    check("dl_word1", data_read, 16'h7856);

    // Reset in the middle of a read slot
    sdram_addr = 22'h012345;
    @(posedge clk); #1 cen12 = 1'b1;
    @(posedge clk); #1 cen12 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd", cmd, C_NOP);
    check("mid_rst_loop_rst", loop_rst, 1'b1);
    check("mid_rst_dq_released", dut.dq_oe_q, 1'b0);
    check("mid_rst_data_read", data_read, 16'h0000);
    ref0 = n_ref; lmr0 = n_lmr;
    wait_init("reinit");
    check("reinit_refresh", n_ref - ref0, 2);
    check("reinit_lmr", n_lmr - lmr0, 1);
    exp_q.push_back(16'hBEEF);
    do_slot(1'b0, 25'h0, 8'h0);
    check("post_reinit_read", data_read, 16'hBEEF);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
